// File: rtl/nunchuk_pkg.sv
// Shared types and command encodings for the nunchuk poller.
// The master command word is {wr, addr[6:0], sub[7:0], data[7:0], 8'h00}.
package nunchuk_pkg;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_INIT1,
        ST_INIT2,
        ST_POLL_WAIT,
        ST_IDLE,
        ST_READ,
        ST_DECODE,
        ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_WAIT_HI,
        PH_WAIT_LO
    } phase_t;

    typedef struct packed {
        logic [31:0] ctrl;
        logic        read;
    } cmd_t;

    localparam logic [7:0] INIT1_SUB    = 8'hF0;
    localparam logic [7:0] INIT1_DATA   = 8'h55;
    localparam logic [7:0] INIT2_SUB    = 8'hFB;
    localparam logic [7:0] INIT2_DATA   = 8'h00;
    localparam int         REPORT_BYTES = 6;

    function automatic cmd_t cmd_write(input logic [6:0] addr, input logic [7:0] sub,
                                       input logic [7:0] data);
        cmd_t c;
        c.ctrl = {1'b1, addr, sub, data, 8'h00};
        c.read = 1'b0;
        return c;
    endfunction

    function automatic cmd_t cmd_read(input logic [6:0] addr, input logic [7:0] sub);
        cmd_t c;
        c.ctrl = {1'b0, addr, sub, 16'h0000};
        c.read = 1'b1;
        return c;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nunchuk_if.sv
// Command/status link between the nunchuk poller and the I2C master.
interface nunchuk_if;
    logic [31:0] i2c_ctrl_data;
    logic        i2c_wr_ctrl;
    logic        i2c_read;
    logic [31:0] i2c_status;

    modport master (output i2c_ctrl_data, output i2c_wr_ctrl, output i2c_read,
                    input  i2c_status);
    modport slave  (input  i2c_ctrl_data, input  i2c_wr_ctrl, input  i2c_read,
                    output i2c_status);
endinterface

// File: rtl/us_timer.sv
// Microsecond timebase: prescaler divides sys_clock down to 1 us ticks that
// decrement a loadable down-counter; expired is high once the counter is zero.
module us_timer #(
    parameter int CLK_MHZ = 16,
    parameter int W       = 14
) (
    input  logic         sys_clock,
    input  logic         reset,
    input  logic         restart,
    input  logic [W-1:0] load_val,
    output logic         expired
);
    localparam int PW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic [W-1:0]  cnt_q, cnt_d;
    logic          tick;

    assign tick    = (pre_q == PW'(CLK_MHZ - 1));
    assign expired = (cnt_q == '0);

    always_comb begin
        pre_d = pre_q;
        cnt_d = cnt_q;
        if (restart) begin
            pre_d = '0;
            cnt_d = load_val;
        end else begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick && (cnt_q != '0)) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/nunchuk_poller.sv
// Initialises the nunchuk through the I2C master, then polls and decodes its
// 6-byte report.
//   state      | meaning
//   BOOT       | wait for the master to finish its own init (busy low)
//   INIT1      | write F0<=55
//   INIT2      | write FB<=00, then connected
//   POLL_WAIT  | wait POLL_US between reports
//   IDLE       | parked while enable is low
//   READ       | read report byte idx (0..5)
//   DECODE     | publish all fields, pulse sample_valid
//   ERR        | count error, drop connected, wait POLL_US, re-init
module nunchuk_poller
    import nunchuk_pkg::*;
#(
    parameter int         CLK_MHZ    = 16,
    parameter int         POLL_US    = 10000,
    parameter logic [6:0] I2C_ADDR   = 7'h52,
    parameter int         TIMEOUT_US = 2000
) (
    input  logic        sys_clock,
    input  logic        reset,
    input  logic        enable,
    nunchuk_if.master   bus,
    output logic [7:0]  joy_x,
    output logic [7:0]  joy_y,
    output logic [9:0]  acc_x,
    output logic [9:0]  acc_y,
    output logic [9:0]  acc_z,
    output logic        btn_c,
    output logic        btn_z,
    output logic        sample_valid,
    output logic        connected,
    output logic [7:0]  err_count
);
    localparam int TW = $clog2(max_int(POLL_US, TIMEOUT_US) + 1);

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic        read_q, read_d;
    logic        wr_ctrl_q, wr_ctrl_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  rpt_q [REPORT_BYTES];
    logic [7:0]  rpt_d [REPORT_BYTES];
    logic [7:0]  joy_x_q, joy_x_d, joy_y_q, joy_y_d;
    logic [9:0]  acc_x_q, acc_x_d, acc_y_q, acc_y_d, acc_z_q, acc_z_d;
    logic        btn_c_q, btn_c_d, btn_z_q, btn_z_d;
    logic        sample_valid_q, sample_valid_d;
    logic        connected_q, connected_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        busy, nack, in_cmd, done, hung, last_byte, cmd_load;
    logic        tmr_restart, tmr_expired;
    logic [TW-1:0] tmr_load;
    logic        unused_status;
    cmd_t        cmd;

    assign busy          = bus.i2c_status[31];
    assign nack          = bus.i2c_status[30] | bus.i2c_status[29];
    assign unused_status = ^bus.i2c_status[28:8];
    assign in_cmd        = (state_q == ST_INIT1) || (state_q == ST_INIT2) || (state_q == ST_READ);
    assign done          = in_cmd && (phase_q == PH_WAIT_LO) && !busy;
    assign hung          = in_cmd && (phase_q != PH_ISSUE) && tmr_expired;
    assign last_byte     = (idx_q == 3'(REPORT_BYTES - 1));

    // Timeout spans the whole transaction, so it is armed once at the wr_ctrl pulse.
    assign tmr_restart = (state_d != state_q) || ((phase_q == PH_ISSUE) && (phase_d == PH_WAIT_HI));
    assign tmr_load    = ((state_d == ST_POLL_WAIT) || (state_d == ST_ERR)) ? TW'(POLL_US)
                                                                            : TW'(TIMEOUT_US);

    us_timer #(.CLK_MHZ(CLK_MHZ), .W(TW)) u_timer (
        .sys_clock (sys_clock),
        .reset     (reset),
        .restart   (tmr_restart),
        .load_val  (tmr_load),
        .expired   (tmr_expired)
    );

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_BOOT;
            phase_q        <= PH_ISSUE;
            ctrl_q         <= '0;
            read_q         <= 1'b0;
            wr_ctrl_q      <= 1'b0;
            idx_q          <= '0;
            for (int i = 0; i < REPORT_BYTES; i++) rpt_q[i] <= '0;
            joy_x_q        <= '0;
            joy_y_q        <= '0;
            acc_x_q        <= '0;
            acc_y_q        <= '0;
            acc_z_q        <= '0;
            btn_c_q        <= 1'b0;
            btn_z_q        <= 1'b0;
            sample_valid_q <= 1'b0;
            connected_q    <= 1'b0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            ctrl_q         <= ctrl_d;
            read_q         <= read_d;
            wr_ctrl_q      <= wr_ctrl_d;
            idx_q          <= idx_d;
            rpt_q          <= rpt_d;
            joy_x_q        <= joy_x_d;
            joy_y_q        <= joy_y_d;
            acc_x_q        <= acc_x_d;
            acc_y_q        <= acc_y_d;
            acc_z_q        <= acc_z_d;
            btn_c_q        <= btn_c_d;
            btn_z_q        <= btn_z_d;
            sample_valid_q <= sample_valid_d;
            connected_q    <= connected_d;
            err_count_q    <= err_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            ST_BOOT: if (!busy) begin
                state_d = ST_INIT1;
                phase_d = PH_ISSUE;
            end
            ST_INIT1, ST_INIT2, ST_READ: begin
                case (phase_q)
                    PH_ISSUE:   if (!busy) phase_d = PH_WAIT_HI;
                    PH_WAIT_HI: if (busy)  phase_d = PH_WAIT_LO;
                    default:    ;
                endcase
                if (done) begin
                    phase_d = PH_ISSUE;
                    if (nack)                    state_d = ST_ERR;
                    else if (state_q == ST_INIT1) state_d = ST_INIT2;
                    else if (state_q == ST_INIT2) state_d = ST_POLL_WAIT;
                    else if (last_byte)           state_d = ST_DECODE;
                end else if (hung) begin
                    state_d = ST_ERR;
                    phase_d = PH_ISSUE;
                end
            end
            ST_POLL_WAIT: if (tmr_expired) begin
                state_d = enable ? ST_READ : ST_IDLE;
                phase_d = PH_ISSUE;
            end
            ST_IDLE:   if (enable) state_d = ST_POLL_WAIT;
            ST_DECODE: state_d = ST_POLL_WAIT;
            ST_ERR: if (tmr_expired) begin
                state_d = ST_INIT1;
                phase_d = PH_ISSUE;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // A new command word is latched whenever a command state (re)enters its issue phase.
    assign cmd_load = ((state_d == ST_INIT1) || (state_d == ST_INIT2) || (state_d == ST_READ))
                      && (phase_d == PH_ISSUE)
                      && ((state_d != state_q) || (phase_q != PH_ISSUE));

    always_comb begin
        ctrl_d         = ctrl_q;
        read_d         = read_q;
        idx_d          = idx_q;
        rpt_d          = rpt_q;
        joy_x_d        = joy_x_q;
        joy_y_d        = joy_y_q;
        acc_x_d        = acc_x_q;
        acc_y_d        = acc_y_q;
        acc_z_d        = acc_z_q;
        btn_c_d        = btn_c_q;
        btn_z_d        = btn_z_q;
        connected_d    = connected_q;
        err_count_d    = err_count_q;
        wr_ctrl_d      = in_cmd && (phase_q == PH_ISSUE) && !busy;
        sample_valid_d = (state_q == ST_DECODE);
        cmd            = '0;

        if ((state_q == ST_READ) && done && !nack) begin
            rpt_d[idx_q] = bus.i2c_status[7:0];
            if (!last_byte) idx_d = idx_q + 3'd1;
        end
        if ((state_q == ST_INIT2) && done && !nack) begin
            connected_d = 1'b1;
            idx_d       = '0;
        end
        if (state_q == ST_DECODE) begin
            idx_d   = '0;
            joy_x_d = rpt_q[0];
            joy_y_d = rpt_q[1];
            acc_x_d = {rpt_q[2], rpt_q[5][3:2]};
            acc_y_d = {rpt_q[3], rpt_q[5][5:4]};
            acc_z_d = {rpt_q[4], rpt_q[5][7:6]};
            btn_c_d = ~rpt_q[5][1];
            btn_z_d = ~rpt_q[5][0];
        end
        if ((state_d == ST_ERR) && (state_q != ST_ERR)) begin
            connected_d = 1'b0;
            idx_d       = '0;
            err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
        end
        if (cmd_load) begin
            case (state_d)
                ST_INIT1: cmd = cmd_write(I2C_ADDR, INIT1_SUB, INIT1_DATA);
                ST_INIT2: cmd = cmd_write(I2C_ADDR, INIT2_SUB, INIT2_DATA);
                default:  cmd = cmd_read(I2C_ADDR, {5'd0, idx_d});
            endcase
            ctrl_d = cmd.ctrl;
            read_d = cmd.read;
        end
    end

    assign bus.i2c_ctrl_data = ctrl_q;
    assign bus.i2c_wr_ctrl   = wr_ctrl_q;
    assign bus.i2c_read      = read_q;
    assign joy_x             = joy_x_q;
    assign joy_y             = joy_y_q;
    assign acc_x             = acc_x_q;
    assign acc_y             = acc_y_q;
    assign acc_z             = acc_z_q;
    assign btn_c             = btn_c_q;
    assign btn_z             = btn_z_q;
    assign sample_valid      = sample_valid_q;
    assign connected         = connected_q;
    assign err_count         = err_count_q;
endmodule

// File: tb/tb_nunchuk_poller.sv
// Bench for nunchuk_poller: behavioural I2C master model plus command and
// sample scoreboards fed with hand-computed expectations.
module tb_nunchuk_poller;
    localparam int BUSY_CYC = 4;

    typedef struct packed {
        logic [7:0] jx;
        logic [7:0] jy;
        logic [9:0] ax;
        logic [9:0] ay;
        logic [9:0] az;
        logic       bc;
        logic       bz;
    } samp_t;

    logic       sys_clock;
    logic       reset;
    logic       enable;
    logic [7:0] joy_x, joy_y, err_count;
    logic [9:0] acc_x, acc_y, acc_z;
    logic       btn_c, btn_z, sample_valid, connected;

    nunchuk_if bus ();

    nunchuk_poller #(
        .CLK_MHZ(2), .POLL_US(20), .I2C_ADDR(7'h52), .TIMEOUT_US(30)
    ) dut (
        .sys_clock(sys_clock), .reset(reset), .enable(enable), .bus(bus),
        .joy_x(joy_x), .joy_y(joy_y), .acc_x(acc_x), .acc_y(acc_y), .acc_z(acc_z),
        .btn_c(btn_c), .btn_z(btn_z), .sample_valid(sample_valid),
        .connected(connected), .err_count(err_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cmd_seen = 0;
    int samp_seen = 0;
    int nack_count = 0;
    int last_wr_cyc = 0;
    logic boot_done = 1'b0;
    logic hang = 1'b0;
    logic nack_all = 1'b0;
    logic sat_mode = 1'b0;
    logic [7:0] nack_sub = 8'hFF;
    logic [7:0] tbl [6];
    logic [32:0] cmd_q [$];
    samp_t samp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_tbl(input int which);
        if (which == 1) begin
            tbl[0] = 8'h80; tbl[1] = 8'h7F; tbl[2] = 8'hA0;
            tbl[3] = 8'h60; tbl[4] = 8'hB3; tbl[5] = 8'h8E;
        end else begin
            tbl[0] = 8'h12; tbl[1] = 8'h34; tbl[2] = 8'h56;
            tbl[3] = 8'h78; tbl[4] = 8'h9A; tbl[5] = 8'h4D;
        end
    endtask

    task automatic push_cmd(input logic [31:0] c, input logic r);
        cmd_q.push_back({c, r});
    endtask

    task automatic push_init();
        push_cmd(32'hD2F05500, 1'b0);
        push_cmd(32'hD2FB0000, 1'b0);
    endtask

    task automatic push_reads(input int n);
        for (int i = 0; i < n; i++) push_cmd(32'h52000000 + (i << 16), 1'b1);
    endtask

    task automatic push_samp(input int which);
        samp_t s;
        if (which == 1) s = '{jx: 8'h80, jy: 8'h7F, ax: 10'h283, ay: 10'h180, az: 10'h2CE, bc: 1'b0, bz: 1'b1};
        else            s = '{jx: 8'h12, jy: 8'h34, ax: 10'h15B, ay: 10'h1E0, az: 10'h269, bc: 1'b1, bz: 1'b0};
        samp_q.push_back(s);
    endtask

    task automatic wait_samples(input int n);
        for (int i = 0; i < 3000 && samp_seen < n; i++) @(negedge sys_clock);
        chk("sample_arrived", samp_seen >= n, 1);
    endtask

    task automatic wait_cmds(input int n);
        for (int i = 0; i < 3000 && cmd_seen < n; i++) @(negedge sys_clock);
        chk("cmd_arrived", cmd_seen >= n, 1);
    endtask

    task automatic wait_err(input int n);
        for (int i = 0; i < 1000 && err_count != 8'(n); i++) @(negedge sys_clock);
        chk("err_count", err_count, n);
    endtask

    initial begin
        sys_clock = 1'b0;
        forever #5 sys_clock = ~sys_clock;
    end

    initial forever begin
        @(negedge sys_clock);
        cyc++;
    end

    // I2C master model: busy one cycle after wr_ctrl, BUSY_CYC cycles busy (or until hang clears).
    initial begin
        logic [31:0] cap_ctrl;
        logic        cap_rd;
        logic        txn_hung;
        logic        nk;
        bus.i2c_status = 32'h8000_0000;
        @(negedge reset);
        repeat (100) @(negedge sys_clock);
        bus.i2c_status = 32'h0;
        boot_done = 1'b1;
        forever begin
            @(negedge sys_clock);
            if (bus.i2c_wr_ctrl === 1'b1) begin
                cap_ctrl = bus.i2c_ctrl_data;
                cap_rd   = bus.i2c_read;
                txn_hung = 1'b0;
                @(negedge sys_clock);
                chk("wr_ctrl_single_pulse", bus.i2c_wr_ctrl, 0);
                bus.i2c_status = 32'h8000_0000;
                repeat (BUSY_CYC) @(negedge sys_clock);
                while (hang) begin
                    txn_hung = 1'b1;
                    @(negedge sys_clock);
                end
                if (!txn_hung) chk("ctrl_read_stable", {bus.i2c_ctrl_data, bus.i2c_read}, {cap_ctrl, cap_rd});
                nk = nack_all || (cap_rd && (cap_ctrl[23:16] == nack_sub));
                if (nk) nack_count++;
                bus.i2c_status = {1'b0, nk, 22'h0, cap_rd ? tbl[cap_ctrl[18:16]] : 8'h00};
            end
        end
    end

    // Scoreboard monitor: pops expectations whenever the DUT issues a command or a sample.
    initial forever begin
        logic [32:0] exp_c;
        samp_t       exp_s;
        @(negedge sys_clock);
        if (!reset) begin
            if (bus.i2c_wr_ctrl === 1'b1) begin
                cmd_seen++;
                last_wr_cyc = cyc;
                chk("no_wr_ctrl_during_boot", boot_done, 1);
                if (sat_mode) begin
                    chk("reinit_cmd", {bus.i2c_ctrl_data, bus.i2c_read}, {32'hD2F05500, 1'b0});
                end else if (cmd_q.size() == 0) begin
                    chk("unexpected_cmd", {bus.i2c_ctrl_data, bus.i2c_read}, 33'h0);
                end else begin
                    exp_c = cmd_q.pop_front();
                    chk("cmd", {bus.i2c_ctrl_data, bus.i2c_read}, exp_c);
                end
            end
            if (sample_valid === 1'b1) begin
                samp_seen++;
                if (samp_q.size() == 0) begin
                    chk("unexpected_sample", 1, 0);
                end else begin
                    exp_s = samp_q.pop_front();
                    chk("sample", {joy_x, joy_y, acc_x, acc_y, acc_z, btn_c, btn_z}, exp_s);
                end
            end
        end
    end

    initial begin
        int base, t_mark, n0;
        reset  = 1'b1;
        enable = 1'b1;
        set_tbl(1);
        repeat (3) @(negedge sys_clock);
        chk("rst_ctrl_data", bus.i2c_ctrl_data, 0);
        chk("rst_read", bus.i2c_read, 0);
        chk("rst_wr_ctrl", bus.i2c_wr_ctrl, 0);
        chk("rst_connected", connected, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_outputs", {joy_x, joy_y, acc_x, acc_y, acc_z, btn_c, btn_z, sample_valid}, 0);

        push_init();
        push_reads(6);
        push_samp(1);
        reset = 1'b0;
        wait_samples(1);
        chk("connected_after_init", connected, 1);
        chk("no_errors_yet", err_count, 0);

        set_tbl(2);
        push_reads(6);
        push_samp(2);
        wait_samples(2);

        nack_sub = 8'h02;
        push_reads(3);
        push_init();
        push_reads(6);
        push_samp(2);
        wait_err(1);
        t_mark = cyc;
        chk("nack_connected", connected, 0);
        chk("nack_outputs_kept", {joy_x, acc_x, btn_c}, {8'h12, 10'h15B, 1'b1});
        base = cmd_seen;
        nack_sub = 8'hFF;
        wait_cmds(base + 1);
        chk("reinit_after_poll_us", (last_wr_cyc - t_mark >= 38) && (last_wr_cyc - t_mark <= 46), 1);
        wait_samples(3);
        chk("reconnected", connected, 1);

        set_tbl(1);
        base = cmd_seen;
        push_reads(6);
        push_samp(1);
        wait_cmds(base + 2);
        enable = 1'b0;
        wait_samples(4);
        repeat (200) @(negedge sys_clock);
        chk("idle_no_cmd", cmd_seen, base + 6);
        push_reads(6);
        push_samp(1);
        enable = 1'b1;
        wait_samples(5);

        hang = 1'b1;
        base = cmd_seen;
        push_reads(1);
        wait_cmds(base + 1);
        t_mark = last_wr_cyc;
        wait_err(2);
        chk("timeout_duration", (cyc - t_mark >= 57) && (cyc - t_mark <= 65), 1);
        chk("hang_connected", connected, 0);
        chk("cmd_queue_drained", cmd_q.size(), 0);

        n0 = nack_count;
        sat_mode = 1'b1;
        nack_all = 1'b1;
        hang = 1'b0;
        for (int i = 0; i < 40000 && nack_count < n0 + 300; i++) @(negedge sys_clock);
        chk("saturation_nacks", nack_count >= n0 + 300, 1);
        chk("err_count_saturated", err_count, 8'hFF);
        chk("sat_connected", connected, 0);

        sat_mode = 1'b0;
        nack_all = 1'b0;
        push_init();
        push_reads(6);
        push_samp(1);
        wait_samples(6);
        chk("final_connected", connected, 1);
        chk("err_count_held", err_count, 8'hFF);
        chk("cmd_queue_empty", cmd_q.size(), 0);
        chk("samp_queue_empty", samp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
